// File: rtl/uart_tx_sequencer_if.sv
// Signal bundle between the string sequencer and its environment: the command
// source, the synchronous byte memory and the UART_TX instance.
//
// Handshake semantics: Start_i is a one-cycle request. It is accepted only on
// an edge where the sequencer is idle, which shows as Busy_o=0 in that cycle.
// TxStart_o is the sequencer's valid toward UART_TX. Its ready is !TxBusy_i,
// and a byte transfers on an edge where TxStart_o=1, which already implies
// TxBusy_i=0. MemRead_o requests the byte at MemAddress_o, and that byte must
// appear on MemData_i in the following cycle.
interface uart_tx_sequencer_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
);
  logic                  Start_i;
  logic [ADDR_WIDTH-1:0] Address_i;
  logic [LEN_WIDTH-1:0]  Length_i;
  logic                  Abort_i;
  logic                  Busy_o;
  logic                  Done_o;
  logic [LEN_WIDTH-1:0]  Count_o;
  logic                  MemRead_o;
  logic [ADDR_WIDTH-1:0] MemAddress_o;
  logic [7:0]            MemData_i;
  logic                  TxStart_o;
  logic [7:0]            TxData_o;
  logic                  TxBusy_i;
  logic                  TxDone_i;
  logic [2:0]            State_o;

  // Sequencer side.
  modport master (
    input  Start_i, Address_i, Length_i, Abort_i, MemData_i, TxBusy_i, TxDone_i,
    output Busy_o, Done_o, Count_o, MemRead_o, MemAddress_o, TxStart_o, TxData_o,
    output State_o
  );

  // Environment side: the command source, the memory and UART_TX.
  modport slave (
    output Start_i, Address_i, Length_i, Abort_i, MemData_i, TxBusy_i, TxDone_i,
    input  Busy_o, Done_o, Count_o, MemRead_o, MemAddress_o, TxStart_o, TxData_o,
    input  State_o
  );
endinterface

// File: rtl/uart_tx_sequencer.sv
// Sends a byte string from a synchronous memory through one UART_TX.
// The string ends at a zero byte, at the programmed length, or on abort.
// State_o exposes the FSM encoding for observation.
module uart_tx_sequencer #(
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic Clock,
  input  logic Reset,
  uart_tx_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ   = 3'd1,
    S_LATCH  = 3'd2,
    S_SEND   = 3'd3,
    S_WAIT   = 3'd4,
    S_FINISH = 3'd5
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [LEN_WIDTH-1:0]  r_limit;
  logic [LEN_WIDTH-1:0]  r_count;
  logic [7:0]            r_tx_data;
  logic                  r_abort_pending;

  logic                  w_tx_start;
  logic [LEN_WIDTH-1:0]  w_count_next;

  // An abort in the same cycle suppresses the start, so no new byte enters UART_TX.
  assign w_tx_start   = (r_state == S_SEND) && !bus.TxBusy_i && !bus.Abort_i;
  assign w_count_next = r_count + LEN_WIDTH'(1);

  assign bus.Busy_o       = (r_state != S_IDLE);
  assign bus.Done_o       = (r_state == S_FINISH);
  assign bus.MemRead_o    = (r_state == S_READ);
  assign bus.MemAddress_o = r_ptr;
  assign bus.Count_o      = r_count;
  assign bus.TxStart_o    = w_tx_start;
  assign bus.TxData_o     = r_tx_data;
  assign bus.State_o      = r_state;

  // Main sequencing FSM: fetch, latch, hand off to UART_TX, wait, and repeat.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state         <= S_IDLE;
      r_ptr           <= '0;
      r_limit         <= '0;
      r_count         <= '0;
      r_tx_data       <= '0;
      r_abort_pending <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_abort_pending <= 1'b0;
          if (bus.Start_i) begin
            r_ptr   <= bus.Address_i;
            r_limit <= bus.Length_i;
            r_count <= '0;
            r_state <= (bus.Length_i == '0) ? S_FINISH : S_READ;
          end
        end
        S_READ: begin
          r_state <= bus.Abort_i ? S_FINISH : S_LATCH;
        end
        S_LATCH: begin
          if (bus.Abort_i || (bus.MemData_i == 8'h00)) begin
            r_state <= S_FINISH;
          end else begin
            r_tx_data <= bus.MemData_i;
            r_state   <= S_SEND;
          end
        end
        S_SEND: begin
          if (bus.Abort_i) begin
            r_state <= S_FINISH;
          end else if (!bus.TxBusy_i) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A short abort pulse is remembered until the in-flight byte finishes.
          if (bus.Abort_i) begin
            r_abort_pending <= 1'b1;
          end
          if (bus.TxDone_i) begin
            r_count <= w_count_next;
            r_ptr   <= r_ptr + ADDR_WIDTH'(1);
            if ((w_count_next == r_limit) || r_abort_pending || bus.Abort_i) begin
              r_state <= S_FINISH;
            end else begin
              r_state <= S_READ;
            end
          end
        end
        S_FINISH: begin
          r_abort_pending <= 1'b0;
          r_state         <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Directed bench for uart_tx_sequencer with a synchronous memory model and a
// simple UART_TX model. The UART_TX model uses a 100-cycle frame, matching
// 1 MHz at 100 kbaud.
module tb_uart_tx_sequencer;

  localparam int FRAME = 100;

  logic Clock = 1'b0;
  logic Reset;

  uart_tx_sequencer_if #(.ADDR_WIDTH(8), .LEN_WIDTH(8)) bus ();

  uart_tx_sequencer #(.ADDR_WIDTH(8), .LEN_WIDTH(8)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  // Clock generation.
  always #5 Clock = ~Clock;

  // Memory model with synchronous reads.
  logic [7:0] mem [0:255];
  logic [7:0] mem_q;
  always @(posedge Clock) begin
    if (bus.MemRead_o) mem_q <= mem[bus.MemAddress_o];
  end
  assign bus.MemData_i = mem_q;

  // UART_TX model: busy for one frame after a start, then a one-cycle done pulse.
  logic tx_busy;
  logic tx_done;
  logic force_busy;
  int   tx_cnt;
  always @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
      tx_cnt  <= 0;
    end else begin
      tx_done <= 1'b0;
      if (tx_busy) begin
        if (tx_cnt == 0) begin
          tx_busy <= 1'b0;
          tx_done <= 1'b1;
        end else begin
          tx_cnt <= tx_cnt - 1;
        end
      end else if (bus.TxStart_o) begin
        tx_busy <= 1'b1;
        tx_cnt  <= FRAME - 2;
      end
    end
  end
  assign bus.TxBusy_i = tx_busy | force_busy;
  assign bus.TxDone_i = tx_done;

  // Monitor: records sent bytes, start pulses, done pulses and memory reads.
  logic [7:0] obs_bytes [0:63];
  int         obs_n   = 0;
  int         done_n  = 0;
  int         read_n  = 0;
  logic [7:0] last_rd = 8'h00;
  always @(negedge Clock) begin
    if (bus.TxStart_o) begin
      obs_bytes[obs_n[5:0]] <= bus.TxData_o;
      obs_n <= obs_n + 1;
    end
    if (bus.Done_o) done_n <= done_n + 1;
    if (bus.MemRead_o) begin
      read_n  <= read_n + 1;
      last_rd <= bus.MemAddress_o;
    end
  end

  // Scoreboard state and counters.
  logic [7:0] exp_q [$];
  int vectors    = 0;
  int miscompares = 0;
  int base_obs, base_done, base_read;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic snapshot();
    base_obs  = obs_n;
    base_done = done_n;
    base_read = read_n;
  endtask

  task automatic wait_done(input string tag, input int limit);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge Clock);
      if (bus.Done_o) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic wait_starts(input string tag, input int target, input int limit);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge Clock);
      if (obs_n - base_obs >= target) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_starts_seen"}, 32'(seen), 32'd1);
  endtask

  // Compares the bytes sent since the last snapshot with exp_q.
  task automatic check_bytes(input string tag);
    int n;
    n = exp_q.size();
    check({tag, "_nbytes"}, 32'(obs_n - base_obs), 32'(n));
    for (int i = 0; i < n; i++) begin
      check({tag, "_byte"}, 32'(obs_bytes[(base_obs + i) % 64]), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic start_cmd(input logic [7:0] addr, input logic [7:0] len);
    bus.Start_i   = 1'b1;
    bus.Address_i = addr;
    bus.Length_i  = len;
    @(negedge Clock);
    bus.Start_i   = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},    32'(bus.Busy_o),       32'd0);
    check({tag, "_done"},    32'(bus.Done_o),       32'd0);
    check({tag, "_count"},   32'(bus.Count_o),      32'd0);
    check({tag, "_memrd"},   32'(bus.MemRead_o),    32'd0);
    check({tag, "_memaddr"}, 32'(bus.MemAddress_o), 32'd0);
    check({tag, "_txstart"}, 32'(bus.TxStart_o),    32'd0);
    check({tag, "_txdata"},  32'(bus.TxData_o),     32'd0);
    check({tag, "_state"},   32'(bus.State_o),      32'd0);
  endtask

  initial begin
    bit hold_ok;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'h48; mem[8'h11] = 8'h65; mem[8'h12] = 8'h6C;
    mem[8'h13] = 8'h6C; mem[8'h14] = 8'h6F; mem[8'h15] = 8'h00;
    mem[8'hFE] = 8'h41; mem[8'hFF] = 8'h42; mem[8'h00] = 8'h43; mem[8'h01] = 8'h00;

    bus.Start_i   = 1'b0;
    bus.Address_i = 8'h00;
    bus.Length_i  = 8'h00;
    bus.Abort_i   = 1'b0;
    force_busy    = 1'b0;
    Reset         = 1'b0;

    // Check the reset state.
    repeat (3) @(negedge Clock);
    check_all_zero("reset");
    Reset = 1'b1;
    repeat (2) @(negedge Clock);

    // Send "Hello" with length 8, checking the first-byte latency.
    snapshot();
    start_cmd(8'h10, 8'd8);
    check("hello_rd_cycle", 32'(bus.MemRead_o), 32'd1);
    check("hello_rd_addr", 32'(bus.MemAddress_o), 32'h10);
    check("hello_busy", 32'(bus.Busy_o), 32'd1);
    @(negedge Clock);
    check("hello_latch_nord", 32'(bus.MemRead_o), 32'd0);
    @(negedge Clock);
    check("hello_first_start", 32'(bus.TxStart_o), 32'd1);
    check("hello_first_data", 32'(bus.TxData_o), 32'h48);
    wait_done("hello", 1000);
    @(negedge Clock);
    check("hello_busy_after", 32'(bus.Busy_o), 32'd0);
    exp_q = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};
    check_bytes("hello");
    check("hello_done_n", 32'(done_n - base_done), 32'd1);
    check("hello_count", 32'(bus.Count_o), 32'd5);
    check("hello_reads", 32'(read_n - base_read), 32'd6);
    check("hello_last_rd", 32'(last_rd), 32'h15);

    // Length 3 stops after the third byte.
    snapshot();
    start_cmd(8'h10, 8'd3);
    wait_done("len3", 1000);
    @(negedge Clock);
    exp_q = '{8'h48, 8'h65, 8'h6C};
    check_bytes("len3");
    check("len3_count", 32'(bus.Count_o), 32'd3);
    check("len3_reads", 32'(read_n - base_read), 32'd3);
    check("len3_last_rd", 32'(last_rd), 32'h12);

    // Length 0 produces only a done pulse.
    snapshot();
    start_cmd(8'h20, 8'd0);
    check("len0_done", 32'(bus.Done_o), 32'd1);
    check("len0_busy", 32'(bus.Busy_o), 32'd1);
    check("len0_count", 32'(bus.Count_o), 32'd0);
    @(negedge Clock);
    check("len0_done_end", 32'(bus.Done_o), 32'd0);
    check("len0_idle", 32'(bus.Busy_o), 32'd0);
    check("len0_reads", 32'(read_n - base_read), 32'd0);
    check("len0_starts", 32'(obs_n - base_obs), 32'd0);

    // Pointer wrap from 0xFE. Abort arriving with the start is ignored.
    snapshot();
    bus.Abort_i = 1'b1;
    start_cmd(8'hFE, 8'd8);
    bus.Abort_i = 1'b0;
    wait_done("wrap", 1000);
    @(negedge Clock);
    exp_q = '{8'h41, 8'h42, 8'h43};
    check_bytes("wrap");
    check("wrap_count", 32'(bus.Count_o), 32'd3);
    check("wrap_reads", 32'(read_n - base_read), 32'd4);
    check("wrap_last_rd", 32'(last_rd), 32'h01);

    // Abort during byte 2. A start issued while busy is ignored.
    snapshot();
    start_cmd(8'h10, 8'd8);
    wait_starts("abort", 2, 1000);
    repeat (10) @(negedge Clock);
    check("abort_in_wait", 32'(bus.State_o), 32'd4);
    bus.Abort_i   = 1'b1;
    bus.Start_i   = 1'b1;
    bus.Address_i = 8'hFE;
    bus.Length_i  = 8'd1;
    @(negedge Clock);
    bus.Abort_i   = 1'b0;
    bus.Start_i   = 1'b0;
    wait_done("abort", 1000);
    repeat (5) @(negedge Clock);
    exp_q = '{8'h48, 8'h65};
    check_bytes("abort");
    check("abort_count", 32'(bus.Count_o), 32'd2);
    check("abort_idle", 32'(bus.Busy_o), 32'd0);
    check("abort_reads", 32'(read_n - base_read), 32'd2);

    // Abort in the same SEND cycle as a possible start suppresses that start.
    snapshot();
    force_busy = 1'b1;
    start_cmd(8'h10, 8'd8);
    repeat (2) @(negedge Clock);
    check("sendabort_state", 32'(bus.State_o), 32'd3);
    force_busy  = 1'b0;
    bus.Abort_i = 1'b1;
    #1;
    check("sendabort_nostart", 32'(bus.TxStart_o), 32'd0);
    @(negedge Clock);
    bus.Abort_i = 1'b0;
    check("sendabort_done", 32'(bus.Done_o), 32'd1);
    check("sendabort_count", 32'(bus.Count_o), 32'd0);
    @(negedge Clock);
    check("sendabort_starts", 32'(obs_n - base_obs), 32'd0);

    // TxBusy held for 20 cycles in SEND, then reset during WAIT.
    force_busy = 1'b1;
    start_cmd(8'h10, 8'd8);
    repeat (2) @(negedge Clock);
    hold_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (bus.TxStart_o !== 1'b0 || bus.State_o !== 3'd3) hold_ok = 1'b0;
      @(negedge Clock);
    end
    check("hold_no_start", 32'(hold_ok), 32'd1);
    force_busy = 1'b0;
    #1;
    check("hold_release_start", 32'(bus.TxStart_o), 32'd1);
    check("hold_release_data", 32'(bus.TxData_o), 32'h48);
    repeat (10) @(negedge Clock);
    check("hold_in_wait", 32'(bus.State_o), 32'd4);
    Reset = 1'b0;
    #1;
    check_all_zero("midreset");
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);

    // A normal string after the mid-string reset.
    snapshot();
    start_cmd(8'h10, 8'd3);
    wait_done("post_reset", 1000);
    @(negedge Clock);
    exp_q = '{8'h48, 8'h65, 8'h6C};
    check_bytes("post_reset");
    check("post_reset_count", 32'(bus.Count_o), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
